// File: rtl/ex_stage_hs.sv
// Handshaked integer execute stage: single-cycle ALU ops plus a fixed-latency
// multiply/MAC path, feeding a valid/ready output register towards MEM.
module ex_stage_hs #(
    parameter int XLEN    = 32,
    parameter int IMM_W   = 16,
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [3:0]        op,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    input  logic [XLEN-1:0]   src3,
    input  logic [XLEN-1:0]   pc,
    input  logic [IMM_W-1:0]  imm,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              branch,
    input  logic [XLEN-1:0]   store_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_out,
    output logic [XLEN-1:0]   branch_addr,
    output logic [XLEN-1:0]   store_data_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_to_reg_o,
    output logic              branch_taken_o,
    output logic              busy
);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [3:0]        op;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [XLEN-1:0]   src3;
        logic [XLEN-1:0]   pc;
        logic [IMM_W-1:0]  imm;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic [XLEN-1:0]   store_data;
    } req_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    req_t              in_req, hold, cur;
    logic              out_free, accept, mul_path, load;
    logic [XLEN-1:0]   product, alu_d, imm_ext;
    logic              src_eq, taken_d;

    always_comb begin
        in_req.op         = op;
        in_req.src1       = src1;
        in_req.src2       = src2;
        in_req.src3       = src3;
        in_req.pc         = pc;
        in_req.imm        = imm;
        in_req.rd         = rd_addr;
        in_req.reg_write  = reg_write;
        in_req.mem_read   = mem_read;
        in_req.mem_write  = mem_write;
        in_req.mem_to_reg = mem_to_reg;
        in_req.branch     = branch;
        in_req.store_data = store_data;
    end

    assign out_free = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // MUL_LAT==1 sends multiplies straight to the output like any ALU op.
    assign mul_path = (op == 4'd3 || op == 4'd4) && (MUL_LAT > 1);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // NOTE: defaults first so no path through the block leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: if (accept && mul_path) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                end
                BUSY: if (cnt > CNT_W'(1)) begin
                    cnt_d = cnt - CNT_W'(1);
                end else if (out_free) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state == BUSY);
        in_ready = !rst && !flush && (state == IDLE) && out_free;
        load     = !flush && ((state == IDLE && accept && !mul_path) ||
                              (state == BUSY && cnt == CNT_W'(1) && out_free));
    end

    // NOTE: the operand hold register has no reset; it is only read in BUSY,
    // which is always entered by writing it first.
    always_ff @(posedge clk) begin
        if (accept && mul_path) hold <= in_req;
    end

    assign cur     = (state == BUSY) ? hold : in_req;
    assign product = cur.src1 * cur.src2;
    assign src_eq  = (cur.src1 == cur.src2);
    assign imm_ext = {{(XLEN-IMM_W){cur.imm[IMM_W-1]}}, cur.imm};

    always_comb begin
        case (cur.op)
            4'd0:       alu_d = cur.src1 & cur.src2;
            4'd1:       alu_d = cur.src1 | cur.src2;
            4'd2:       alu_d = cur.src1 + cur.src2;
            4'd3:       alu_d = product;
            4'd4:       alu_d = product + cur.src3;
            4'd5, 4'd6: alu_d = cur.src1 - cur.src2;
            4'd7:       alu_d = XLEN'(cur.src1 < cur.src2);
            default:    alu_d = '0;
        endcase
        taken_d = cur.branch && ((cur.op == 4'd5 && src_eq) || (cur.op == 4'd6 && !src_eq));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            alu_out        <= '0;
            branch_addr    <= '0;
            store_data_o   <= '0;
            rd_addr_o      <= '0;
            reg_write_o    <= 1'b0;
            mem_read_o     <= 1'b0;
            mem_write_o    <= 1'b0;
            mem_to_reg_o   <= 1'b0;
            branch_taken_o <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid      <= 1'b1;
            alu_out        <= alu_d;
            branch_addr    <= cur.pc + (imm_ext << 2);
            store_data_o   <= cur.store_data;
            rd_addr_o      <= cur.rd;
            reg_write_o    <= cur.reg_write;
            mem_read_o     <= cur.mem_read;
            mem_write_o    <= cur.mem_write;
            mem_to_reg_o   <= cur.mem_to_reg;
            branch_taken_o <= taken_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage_hs.sv
// Bench for ex_stage_hs: cycle-level reference model with a per-cycle compare,
// plus directed checks against hand-computed values.
module tb_ex_stage_hs;
    localparam int XLEN = 32, IMM_W = 16, REG_AW = 5, MUL_LAT = 4;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [3:0] op;
    logic [31:0] src1, src2, src3, pc, store_data;
    logic [15:0] imm;
    logic [4:0] rd_addr, rd_addr_o;
    logic reg_write, mem_read, mem_write, mem_to_reg, branch;
    logic [31:0] alu_out, branch_addr, store_data_o;
    logic reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_taken_o;

    logic in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [31:0] alu_out1, branch_addr1, store_data_o1;
    logic [4:0] rd_addr_o1;
    logic reg_write_o1, mem_read_o1, mem_write_o1, mem_to_reg_o1, branch_taken_o1;

    ex_stage_hs #(.XLEN(XLEN), .IMM_W(IMM_W), .REG_AW(REG_AW), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .op(op), .src1(src1), .src2(src2), .src3(src3), .pc(pc), .imm(imm),
        .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch),
        .store_data(store_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .branch_addr(branch_addr), .store_data_o(store_data_o),
        .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
        .branch_taken_o(branch_taken_o), .busy(busy));

    ex_stage_hs #(.XLEN(XLEN), .IMM_W(IMM_W), .REG_AW(REG_AW), .MUL_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .flush(flush),
        .op(op), .src1(src1), .src2(src2), .src3(src3), .pc(pc), .imm(imm),
        .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch),
        .store_data(store_data), .out_valid(out_valid1), .out_ready(out_ready1),
        .alu_out(alu_out1), .branch_addr(branch_addr1), .store_data_o(store_data_o1),
        .rd_addr_o(rd_addr_o1), .reg_write_o(reg_write_o1), .mem_read_o(mem_read_o1),
        .mem_write_o(mem_write_o1), .mem_to_reg_o(mem_to_reg_o1),
        .branch_taken_o(branch_taken_o1), .busy(busy1));

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] alu, ba, sd;
        logic [4:0]  rd;
        logic [4:0]  ctrl;  // {reg_write, mem_read, mem_write, mem_to_reg, taken}
    } res_t;

    function automatic res_t calc(input logic [3:0] o, input logic [31:0] a, b, c, p,
                                  input logic [15:0] im, input logic [4:0] rd,
                                  input logic rw, mr, mw, mtr, br, input logic [31:0] sd);
        res_t res;
        longint unsigned x = a, y = b, z = c, r;
        longint signed off;
        case (o)
            4'd0:       r = x & y;
            4'd1:       r = x | y;
            4'd2:       r = x + y;
            4'd3:       r = x * y;
            4'd4:       r = x * y + z;
            4'd5, 4'd6: r = x - y;
            4'd7:       r = (x < y) ? 1 : 0;
            default:    r = 0;
        endcase
        off      = longint'($signed(im)) * 4;
        res.alu  = r[31:0];
        res.ba   = 32'(longint'(p) + off);
        res.sd   = sd;
        res.rd   = rd;
        res.ctrl = {rw, mr, mw, mtr, br && ((o == 4'd5 && a == b) || (o == 4'd6 && a != b))};
        return res;
    endfunction

    // Reference model: a result exists or not; a multiply becomes deliverable
    // MUL_LAT-1 edges after acceptance and waits for a free output slot.
    logic m_valid = 1'b0, m_pend = 1'b0;
    res_t m_out, m_pres, m_res;
    int cyc = 0, m_done = 0;
    logic m_free, m_rdy, m_acc;

    always_comb begin
        m_free = !m_valid || out_ready;
        m_rdy  = !rst && !flush && !m_pend && m_free;
        m_acc  = in_valid && m_rdy;
        m_res  = calc(op, src1, src2, src3, pc, imm, rd_addr, reg_write, mem_read,
                      mem_write, mem_to_reg, branch, store_data);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_pend  <= 1'b0;
            cyc     <= 0;
        end else begin
            cyc <= cyc + 1;
            if (flush) begin
                m_valid <= 1'b0;
                m_pend  <= 1'b0;
            end else if (m_pend && cyc >= m_done && m_free) begin
                m_valid <= 1'b1;
                m_out   <= m_pres;
                m_pend  <= 1'b0;
            end else if (m_acc && (op == 4'd3 || op == 4'd4) && MUL_LAT > 1) begin
                m_pend  <= 1'b1;
                m_done  <= cyc + MUL_LAT - 1;
                m_pres  <= m_res;
                if (m_valid && out_ready) m_valid <= 1'b0;
            end else if (m_acc) begin
                m_valid <= 1'b1;
                m_out   <= m_res;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_in_ready", in_ready, m_rdy);
        check("cmp_busy", busy, m_pend);
        check("cmp_out_valid", out_valid, m_valid);
        if (rst) begin
            check("cmp_rst_alu", alu_out, 0);
        end else if (m_valid) begin
            check("cmp_alu", alu_out, m_out.alu);
            check("cmp_baddr", branch_addr, m_out.ba);
            check("cmp_sdata", store_data_o, m_out.sd);
            check("cmp_rd", rd_addr_o, m_out.rd);
            check("cmp_ctrl", {reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_taken_o},
                  m_out.ctrl);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a, b, c,
                         input logic [4:0] rd, input logic rw);
        op         = o;
        src1       = a;
        src2       = b;
        src3       = c;
        rd_addr    = rd;
        reg_write  = rw;
        mem_to_reg = rw;
        mem_write  = o[0];
        mem_read   = o[1];
        store_data = a + 32'h1000;
        in_valid   = 1'b1;
    endtask

    initial begin
        in_valid = 0; flush = 0; out_ready = 1; op = 0; src1 = 0; src2 = 0; src3 = 0;
        pc = 32'h40; imm = 16'h3; rd_addr = 0; reg_write = 0; mem_read = 0;
        mem_write = 0; mem_to_reg = 0; branch = 0; store_data = 0;
        in_valid1 = 0; out_ready1 = 1;
        #1 rst = 1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        tick();
        rst = 0;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_busy", busy, 0);
        check("rel_out_valid", out_valid, 0);

        // ADD stream at one op per cycle
        drive(4'd2, 32'h7FFF_FFFF, 32'h1, 0, 5'd3, 1'b1);
        tick();
        drive(4'd2, 32'hFFFF_FFFF, 32'h1, 0, 5'd4, 1'b1);
        @(negedge clk);
        check("add1_alu", alu_out, 32'h8000_0000);
        check("add1_rd", rd_addr_o, 5'd3);
        check("add1_rw", reg_write_o, 1);
        tick();
        in_valid = 0;
        @(negedge clk);
        check("add2_alu", alu_out, 32'h0);
        check("add2_rd", rd_addr_o, 5'd4);
        check("add2_valid", out_valid, 1);

        // MAC on both latencies
        tick();
        drive(4'd4, 32'd3, 32'd5, 32'd7, 5'd9, 1'b1);
        in_valid1 = 1;
        tick();
        in_valid = 0;
        in_valid1 = 0;
        @(negedge clk);
        check("mac_busy_n0", busy, 1);
        check("mac_valid_n0", out_valid, 0);
        check("mac1_valid", out_valid1, 1);
        check("mac1_alu", alu_out1, 32'd22);
        check("mac1_busy", busy1, 0);
        tick();
        @(negedge clk);
        check("mac_busy_n1", busy, 1);
        tick();
        @(negedge clk);
        check("mac_busy_n2", busy, 1);
        check("mac_valid_n2", out_valid, 0);
        tick();
        @(negedge clk);
        check("mac_busy_n3", busy, 0);
        check("mac_valid_n3", out_valid, 1);
        check("mac_alu", alu_out, 32'd22);

        // Backpressure: AND held, MUL waits upstream, then consume+accept together
        tick();
        out_ready = 0;
        drive(4'd0, 32'h0000_F0F0, 32'h0000_0FF0, 0, 5'd1, 1'b1);
        tick();
        drive(4'd3, 32'd6, 32'd7, 0, 5'd7, 1'b1);
        @(negedge clk);
        check("bp_and_alu", alu_out, 32'h0000_00F0);
        check("bp_in_ready", in_ready, 0);
        tick();
        tick();
        @(negedge clk);
        check("bp_hold_alu", alu_out, 32'h0000_00F0);
        check("bp_hold_valid", out_valid, 1);
        out_ready = 1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 0;
        @(negedge clk);
        check("bp_mul_busy", busy, 1);
        repeat (3) tick();
        @(negedge clk);
        check("bp_mul_alu", alu_out, 32'd42);
        check("bp_mul_rd", rd_addr_o, 5'd7);

        // Branches and remaining ALU ops
        tick();
        pc = 32'h100; imm = 16'hFFFF; branch = 1;
        drive(4'd5, 32'd9, 32'd9, 0, 5'd1, 1'b0);
        tick();
        drive(4'd6, 32'd9, 32'd9, 0, 5'd1, 1'b0);
        @(negedge clk);
        check("beq_taken", branch_taken_o, 1);
        check("beq_addr", branch_addr, 32'h0000_00FC);
        check("beq_alu", alu_out, 0);
        tick();
        branch = 0;
        drive(4'd7, 32'd3, 32'd5, 0, 5'd2, 1'b1);
        @(negedge clk);
        check("bne_taken", branch_taken_o, 0);
        check("bne_alu", alu_out, 0);
        tick();
        drive(4'd12, 32'd5, 32'd6, 0, 5'd6, 1'b1);
        @(negedge clk);
        check("sltu_alu", alu_out, 1);
        tick();
        drive(4'd1, 32'hF0, 32'h0F, 0, 5'd8, 1'b1);
        @(negedge clk);
        check("op12_alu", alu_out, 0);
        check("op12_rw", reg_write_o, 1);
        tick();
        in_valid = 0;
        @(negedge clk);
        check("or_alu", alu_out, 32'hFF);

        // Flush during BUSY
        drive(4'd3, 32'd2, 32'd3, 0, 5'd5, 1'b1);
        tick();
        in_valid = 0;
        tick();
        flush = 1;
        drive(4'd2, 32'd1, 32'd1, 0, 5'd5, 1'b1);
        @(negedge clk);
        check("fl_busy_ready", in_ready, 0);
        tick();
        flush = 0;
        in_valid = 0;
        @(negedge clk);
        check("fl_busy_valid", out_valid, 0);
        check("fl_busy_busy", busy, 0);
        check("fl_busy_ready_after", in_ready, 1);
        repeat (4) tick();

        // Flush on the completing edge
        drive(4'd4, 32'd4, 32'd4, 32'd1, 5'd6, 1'b1);
        tick();
        in_valid = 0;
        tick();
        tick();
        flush = 1;
        tick();
        flush = 0;
        @(negedge clk);
        check("fl_done_valid", out_valid, 0);
        repeat (3) tick();

        // Flush with an output held
        out_ready = 0;
        drive(4'd2, 32'd10, 32'd20, 0, 5'd9, 1'b1);
        tick();
        in_valid = 0;
        flush = 1;
        @(negedge clk);
        check("fl_hold_valid", out_valid, 1);
        check("fl_hold_ready", in_ready, 0);
        tick();
        flush = 0;
        @(negedge clk);
        check("fl_hold_cleared", out_valid, 0);
        check("fl_hold_ready_after", in_ready, 1);
        out_ready = 1;

        // Reset in the middle of a MAC
        pc = 32'h200;
        drive(4'd2, 32'h11, 32'h22, 0, 5'd3, 1'b1);
        tick();
        drive(4'd4, 32'd3, 32'd5, 32'd7, 5'd4, 1'b1);
        tick();
        in_valid = 0;
        tick();
        rst = 1;
        #1;
        check("rst_alu", alu_out, 0);
        check("rst_baddr", branch_addr, 0);
        check("rst_rd", rd_addr_o, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        tick();
        tick();
        rst = 0;
        repeat (6) tick();
        @(negedge clk);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
